// File: rtl/ex_result_sched.sv
// Execute-stage result scheduler: picks the source of the EX result each
// cycle and sequences the multi-cycle multiplier and divider (start pulse,
// latency count, pipeline stall, cancel on flush).
module ex_result_sched #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [2:0] ex_src,
    input  logic       flush,
    input  logic       mem_stall,
    output logic       start_mul,
    output logic       start_div,
    output logic       unit_cancel,
    output logic       ex_stall,
    output logic [4:0] sel_signal,
    output logic       result_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_BUSY,
        DIV_BUSY,
        DONE_MUL,
        DONE_DIV
    } state_t;

    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    localparam logic [4:0] SEL_ALU = 5'b00000;
    localparam logic [4:0] SEL_HI  = 5'b10000;
    localparam logic [4:0] SEL_LO  = 5'b01000;
    localparam logic [4:0] SEL_CP0 = 5'b00100;
    localparam logic [4:0] SEL_MUL = 5'b00010;
    localparam logic [4:0] SEL_DIV = 5'b00001;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       start_mul_q, start_mul_d;
    logic       start_div_q, start_div_d;
    logic       cancel_q, cancel_d;
    logic       launch;

    // A mul/div may only be launched from IDLE by a valid, unflushed instruction
    assign launch = (state_q == IDLE) && ex_valid && !flush &&
                    ((ex_src == 3'd4) || (ex_src == 3'd5));

    // Next-state, latency counter and one-cycle pulse computation
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        start_mul_d = 1'b0;
        start_div_d = 1'b0;
        cancel_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    if (ex_src == 3'd4) begin
                        state_d     = MUL_BUSY;
                        count_d     = MUL_LOAD;
                        start_mul_d = 1'b1;
                    end else begin
                        state_d     = DIV_BUSY;
                        count_d     = DIV_LOAD;
                        start_div_d = 1'b1;
                    end
                end
            end
            MUL_BUSY, DIV_BUSY: begin
                if (flush) begin
                    state_d  = IDLE;
                    count_d  = 8'd0;
                    cancel_d = 1'b1;
                end else if (count_q == 8'd0) begin
                    state_d = (state_q == MUL_BUSY) ? DONE_MUL : DONE_DIV;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            DONE_MUL, DONE_DIV: begin
                if (flush || !mem_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 8'd0;
            end
        endcase
    end

    // State and registered pulse outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            start_mul_q <= 1'b0;
            start_div_q <= 1'b0;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            start_mul_q <= start_mul_d;
            start_div_q <= start_div_d;
            cancel_q    <= cancel_d;
        end
    end

    // Combinational mux select, stall and result-valid from state and inputs
    always_comb begin
        sel_signal   = SEL_ALU;
        ex_stall     = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                ex_stall = launch;
                case (ex_src)
                    3'd1:    sel_signal = SEL_HI;
                    3'd2:    sel_signal = SEL_LO;
                    3'd3:    sel_signal = SEL_CP0;
                    default: sel_signal = SEL_ALU;
                endcase
            end
            MUL_BUSY, DIV_BUSY: begin
                ex_stall = !flush;
            end
            DONE_MUL: begin
                result_valid = !flush;
                sel_signal   = flush ? SEL_ALU : SEL_MUL;
            end
            DONE_DIV: begin
                result_valid = !flush;
                sel_signal   = flush ? SEL_ALU : SEL_DIV;
            end
            default: begin
                sel_signal = SEL_ALU;
            end
        endcase
    end

    assign start_mul   = start_mul_q;
    assign start_div   = start_div_q;
    assign unit_cancel = cancel_q;
    assign busy        = (state_q != IDLE);

endmodule
